// File: rtl/dm_pkg.sv
// -----------------------------------------------------------------------------
// dm_pkg
// Shared definitions for the data-memory response block:
//   - DMCtrl access size/sign encoding (same as Funct3 of loads/stores)
//   - FSM state type used by dmem_resp
// -----------------------------------------------------------------------------
package dm_pkg;

   // DMCtrl encoding
   localparam logic [2:0] DM_B  = 3'b000;  // byte, sign-extended
   localparam logic [2:0] DM_H  = 3'b001;  // half, sign-extended
   localparam logic [2:0] DM_W  = 3'b010;  // word
   localparam logic [2:0] DM_BU = 3'b100;  // byte, zero-extended (loads only)
   localparam logic [2:0] DM_HU = 3'b101;  // half, zero-extended (loads only)

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } dm_state_t;

endpackage

// File: rtl/dmem_lane_fmt.sv
// -----------------------------------------------------------------------------
// dmem_lane_fmt
// Combinational lane formatter for the data memory.
//   Stores: produces the per-byte write enables and lane-replicated write data.
//   Loads : extracts the addressed byte/half from the read word and sign- or
//           zero-extends it.
//   Flags illegal accesses (bad DMCtrl, or misaligned when trapping).
// Configuration macro: DMEM_MISALIGN_TRAP_EN
//   defined   -> misaligned H/HU/W accesses raise err
//   undefined -> misaligned low address bits are forced to zero
// Ports:
//   ctrl     in   3  DMCtrl size/sign
//   wr       in   1  1 = store, 0 = load
//   lane     in   2  Address[1:0]
//   wdata    in  32  right-aligned store data
//   rword    in  32  word read from the array
//   be       out  4  byte write enables (0 for loads and errors)
//   wdata_sh out 32  store data placed on its byte lanes
//   rdata    out 32  extended load result (0 for stores and errors)
//   err      out  1  access is illegal
// -----------------------------------------------------------------------------
module dmem_lane_fmt
   import dm_pkg::*;
(
   input  logic [2:0]  ctrl,
   input  logic        wr,
   input  logic [1:0]  lane,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  be,
   output logic [31:0] wdata_sh,
   output logic [31:0] rdata,
   output logic        err
);

   logic       is_b;
   logic       is_h;
   logic       is_w;
   logic       bad_ctrl;
   logic [1:0] alane;     // lane actually used after alignment handling
   logic [7:0]  byte_v;
   logic [15:0] half_v;
`ifdef DMEM_MISALIGN_TRAP_EN
   logic       misal;
`endif

   always_comb begin
      // NOTE: every variable gets a default before any branch, so no path
      // leaves one unassigned and no latch is inferred.
      be       = 4'b0000;
      wdata_sh = wdata;
      rdata    = 32'h0;

      is_b = (ctrl == DM_B) || (ctrl == DM_BU);
      is_h = (ctrl == DM_H) || (ctrl == DM_HU);
      is_w = (ctrl == DM_W);

      // Stores have no unsigned variants: BU/HU encodings are illegal there.
      bad_ctrl = !(is_b || is_h || is_w) || (wr && ctrl[2]);

`ifdef DMEM_MISALIGN_TRAP_EN
      misal = (is_h && lane[0]) || (is_w && (lane != 2'b00));
      err   = bad_ctrl || misal;
      alane = lane;
`else
      err   = bad_ctrl;
      alane = is_w ? 2'b00 : (is_h ? {lane[1], 1'b0} : lane);
`endif

      byte_v = rword[{alane, 3'b000} +: 8];
      half_v = alane[1] ? rword[31:16] : rword[15:0];

      if (!err) begin
         if (wr) begin
            // Data is replicated on every lane; the enables pick the target.
            if (is_b) begin
               be       = 4'b0001 << alane;
               wdata_sh = {4{wdata[7:0]}};
            end else if (is_h) begin
               be       = alane[1] ? 4'b1100 : 4'b0011;
               wdata_sh = {2{wdata[15:0]}};
            end else begin
               be       = 4'b1111;
            end
         end else begin
            if (is_b) begin
               rdata = ctrl[2] ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
            end else if (is_h) begin
               rdata = ctrl[2] ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
            end else begin
               rdata = rword;
            end
         end
      end
   end

endmodule

// File: rtl/dmem_resp.sv
// -----------------------------------------------------------------------------
// dmem_resp
// Single-port data memory behind a valid/ready request/response handshake.
// One transaction: IDLE (accept) -> ACCESS (one read or one byte-enabled
// write) -> RESP (hold result until rsp_ready). Minimum 3 cycles each.
// Configuration macro: DMEM_MISALIGN_TRAP_EN (see dmem_lane_fmt).
// Ports:
//   clk        in   1  clock, rising edge
//   rst        in   1  asynchronous active-high reset
//   req_valid  in   1  request pending
//   req_ready  out  1  request accepted this cycle (IDLE only)
//   Address    in  32  byte address; bits above the array size are ignored
//   DataWr     in  32  right-aligned store data
//   DMWr       in   1  1 = store, 0 = load
//   DMCtrl     in   3  size/sign (B, H, W, BU, HU)
//   rsp_valid  out  1  response available
//   rsp_ready  in   1  response consumed
//   DataRd     out 32  load result (0 for stores and errors)
//   rsp_err    out  1  illegal access
// Array contents are not affected by reset.
// -----------------------------------------------------------------------------
module dmem_resp
   import dm_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] Address,
   input  logic [31:0] DataWr,
   input  logic        DMWr,
   input  logic [2:0]  DMCtrl,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] DataRd,
   output logic        rsp_err
);

   localparam int AW = $clog2(DEPTH_WORDS);

   logic [31:0]   mem [DEPTH_WORDS];

   dm_state_t     state;
   logic [AW+1:0] addr_q;
   logic [31:0]   wdata_q;
   logic          wr_q;
   logic [2:0]    ctrl_q;

   logic [AW-1:0] widx;
   logic [31:0]   rword;
   logic [3:0]    fmt_be;
   logic [31:0]   fmt_wdata;
   logic [31:0]   fmt_rdata;
   logic          fmt_err;

   // Upper address bits wrap around by design.
   logic          addr_hi_unused;
   assign addr_hi_unused = ^Address[31:AW+2];

   assign widx  = addr_q[AW+1:2];
   assign rword = mem[widx];

   dmem_lane_fmt u_fmt (
      .ctrl     (ctrl_q),
      .wr       (wr_q),
      .lane     (addr_q[1:0]),
      .wdata    (wdata_q),
      .rword    (rword),
      .be       (fmt_be),
      .wdata_sh (fmt_wdata),
      .rdata    (fmt_rdata),
      .err      (fmt_err)
   );

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples values from before the edge.
      if (rst) begin
         state     <= IDLE;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         DataRd    <= 32'h0;
         addr_q    <= '0;
         wdata_q   <= 32'h0;
         wr_q      <= 1'b0;
         ctrl_q    <= DM_W;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  addr_q    <= Address[AW+1:0];
                  wdata_q   <= DataWr;
                  wr_q      <= DMWr;
                  ctrl_q    <= DMCtrl;
                  req_ready <= 1'b0;
                  state     <= ACCESS;
               end
            end
            ACCESS: begin
               DataRd    <= fmt_rdata;
               rsp_err   <= fmt_err;
               rsp_valid <= 1'b1;
               state     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  rsp_err   <= 1'b0;
                  DataRd    <= 32'h0;
                  req_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               req_ready <= 1'b1;
               rsp_valid <= 1'b0;
            end
         endcase
      end
   end

   // Write happens on the edge that leaves ACCESS. An asynchronous reset
   // pulled during ACCESS moves state to IDLE first, which cancels the write.
   always_ff @(posedge clk) begin
      // NOTE: the storage array is deliberately left out of reset; clearing
      // it would force a flop-based array and contents must survive reset.
      if (state == ACCESS) begin
         for (int b = 0; b < 4; b++) begin
            if (fmt_be[b]) begin
               mem[widx][8*b +: 8] <= fmt_wdata[8*b +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_dmem_resp.sv
// -----------------------------------------------------------------------------
// tb_dmem_resp
// Directed testbench for dmem_resp. Each transaction is accepted in cycle c,
// is in ACCESS in c+1 and presents its response in c+2. Outputs are sampled
// 1 time unit after the rising edge; inputs are driven at the same point.
// While the DUT is busy the inputs carry a conflicting store request that must
// be ignored.
// -----------------------------------------------------------------------------
module tb_dmem_resp;
   import dm_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] Address;
   logic [31:0] DataWr;
   logic        DMWr;
   logic [2:0]  DMCtrl;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] DataRd;
   logic        rsp_err;

   int n_tests = 0;
   int n_fail  = 0;

   dmem_resp #(.DEPTH_WORDS(1024)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .Address   (Address),
      .DataWr    (DataWr),
      .DMWr      (DMWr),
      .DMCtrl    (DMCtrl),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .DataRd    (DataRd),
      .rsp_err   (rsp_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Full transaction; call 1 unit after a rising edge with the DUT idle.
   task automatic xact(input string tag, input logic wr, input logic [2:0] ctrl,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err, input int hold);
      Address   = addr;
      DataWr    = wd;
      DMWr      = wr;
      DMCtrl    = ctrl;
      req_valid = 1'b1;
      rsp_ready = 1'b0;
      check({tag, "_ready"}, 32'(req_ready), 32'd1);
      @(posedge clk); #1;                  // accepting edge
      Address = addr & ~32'h3;             // conflicting request, must be ignored
      DataWr  = 32'hA5A5A5A5;
      DMWr    = 1'b1;
      DMCtrl  = DM_W;
      check({tag, "_acc_vld"}, 32'(rsp_valid), 32'd0);
      check({tag, "_acc_rdy"}, 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      check({tag, "_vld"}, 32'(rsp_valid), 32'd1);
      check({tag, "_rd"},  DataRd, exp_rd);
      check({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check({tag, "_hold_vld"}, 32'(rsp_valid), 32'd1);
         check({tag, "_hold_rd"},  DataRd, exp_rd);
         check({tag, "_hold_err"}, 32'(rsp_err), 32'(exp_err));
         check({tag, "_hold_rdy"}, 32'(req_ready), 32'd0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      check({tag, "_done_vld"}, 32'(rsp_valid), 32'd0);
      check({tag, "_done_rdy"}, 32'(req_ready), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      rst       = 1'b1;
      req_valid = 1'b0;
      rsp_ready = 1'b0;
      Address   = 32'h0;
      DataWr    = 32'h0;
      DMWr      = 1'b0;
      DMCtrl    = DM_W;
      repeat (2) @(posedge clk);
      #1;
      check("reset_req_ready", 32'(req_ready), 32'd1);
      check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset_rsp_err",   32'(rsp_err),   32'd0);
      check("reset_datard",    DataRd,         32'h0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Word store / load
      xact("sw_100", 1'b1, DM_W, 32'h100, 32'h12345678, 32'h0,        1'b0, 0);
      xact("lw_100", 1'b0, DM_W, 32'h100, 32'h0,        32'h12345678, 1'b0, 0);

      // Byte store, then loads of the same word straight after
      xact("sb_101",  1'b1, DM_B,  32'h101, 32'h000000AB, 32'h0,        1'b0, 0);
      xact("lb_101",  1'b0, DM_B,  32'h101, 32'h0,        32'hFFFFFFAB, 1'b0, 0);
      xact("lbu_101", 1'b0, DM_BU, 32'h101, 32'h0,        32'h000000AB, 1'b0, 0);
      xact("lw_100b", 1'b0, DM_W,  32'h100, 32'h0,        32'h1234AB78, 1'b0, 0);

      // Halfword
      xact("lh_102",  1'b0, DM_H,  32'h102, 32'h0,        32'h00001234, 1'b0, 0);
      xact("sh_102",  1'b1, DM_H,  32'h102, 32'h00008001, 32'h0,        1'b0, 0);
      xact("lh_102b", 1'b0, DM_H,  32'h102, 32'h0,        32'hFFFF8001, 1'b0, 0);
      xact("lhu_102", 1'b0, DM_HU, 32'h102, 32'h0,        32'h00008001, 1'b0, 0);
      xact("lb_100",  1'b0, DM_B,  32'h100, 32'h0,        32'h00000078, 1'b0, 0);

      // Misaligned accesses
`ifdef DMEM_MISALIGN_TRAP_EN
      xact("lw_103",  1'b0, DM_W, 32'h103, 32'h0,        32'h0, 1'b1, 0);
      xact("lh_103",  1'b0, DM_H, 32'h103, 32'h0,        32'h0, 1'b1, 0);
      xact("sw_102",  1'b1, DM_W, 32'h102, 32'h11111111, 32'h0, 1'b1, 0);
      xact("lw_chk1", 1'b0, DM_W, 32'h100, 32'h0,        32'h8001AB78, 1'b0, 0);
`else
      xact("lw_103",  1'b0, DM_W, 32'h103, 32'h0, 32'h8001AB78, 1'b0, 0);
      xact("lh_103",  1'b0, DM_H, 32'h103, 32'h0, 32'hFFFF8001, 1'b0, 0);
`endif

      // Response held for 5 cycles
      xact("lw_hold", 1'b0, DM_W, 32'h100, 32'h0, 32'h8001AB78, 1'b0, 5);

      // Illegal DMCtrl: load with 111, stores with BU/HU encodings (no write)
      xact("ld_111",  1'b0, 3'b111, 32'h100, 32'h0,        32'h0, 1'b1, 0);
      xact("ld_011",  1'b0, 3'b011, 32'h100, 32'h0,        32'h0, 1'b1, 0);
      xact("st_bu",   1'b1, DM_BU,  32'h100, 32'h000000FF, 32'h0, 1'b1, 0);
      xact("st_hu",   1'b1, DM_HU,  32'h100, 32'h0000FFFF, 32'h0, 1'b1, 1);
      xact("lw_chk2", 1'b0, DM_W,   32'h100, 32'h0, 32'h8001AB78, 1'b0, 0);

      // Upper address bits ignored: 0x1100 and 0x80000100 alias 0x100
      xact("lw_wrap", 1'b0, DM_W, 32'h00001100, 32'h0, 32'h8001AB78, 1'b0, 0);
      xact("sw_wrap", 1'b1, DM_W, 32'h80000300, 32'hCAFEF00D, 32'h0, 1'b0, 0);
      xact("lw_300",  1'b0, DM_W, 32'h00000300, 32'h0, 32'hCAFEF00D, 1'b0, 0);

      // Reset during RESP clears outputs immediately
      Address   = 32'h100;
      DMWr      = 1'b0;
      DMCtrl    = DM_W;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      check("pre_rst_rd", DataRd, 32'h8001AB78);
      rst = 1'b1;
      #1;
      check("rst_resp_vld", 32'(rsp_valid), 32'd0);
      check("rst_resp_rd",  DataRd,         32'h0);
      check("rst_resp_rdy", 32'(req_ready), 32'd1);
      #1 rst = 1'b0;
      @(posedge clk); #1;

      // Reset during ACCESS suppresses the store
      xact("sw_200", 1'b1, DM_W, 32'h200, 32'h0BADF00D, 32'h0, 1'b0, 0);
      Address   = 32'h200;
      DataWr    = 32'hDEADBEEF;
      DMWr      = 1'b1;
      DMCtrl    = DM_W;
      req_valid = 1'b1;
      @(posedge clk); #1;                  // now in ACCESS
      req_valid = 1'b0;
      check("acc_busy_rdy", 32'(req_ready), 32'd0);
      rst = 1'b1;
      #1;
      check("rst_acc_rdy", 32'(req_ready), 32'd1);
      check("rst_acc_vld", 32'(rsp_valid), 32'd0);
      check("rst_acc_err", 32'(rsp_err),   32'd0);
      check("rst_acc_rd",  DataRd,         32'h0);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      check("post_rst_vld", 32'(rsp_valid), 32'd0);
      xact("lw_200", 1'b0, DM_W, 32'h200, 32'h0, 32'h0BADF00D, 1'b0, 0);
      xact("lw_100_kept", 1'b0, DM_W, 32'h100, 32'h0, 32'h8001AB78, 1'b0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_resp.md
DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, number of 32-bit words in the storage array (power of two).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 req_valid  input  1  requester has a memory access pending.
REQ-005 req_ready  output  1  block accepts a request this cycle.
REQ-006 Address  input  32  byte address of the access.
REQ-007 DataWr  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-008 DMWr  input  1  1 = store, 0 = load.
REQ-009 DMCtrl  input  3  access size/sign, same encoding as Funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-010 rsp_valid  output  1  response available.
REQ-011 rsp_ready  input  1  requester consumes the response.
REQ-012 DataRd  output  32  load result, sign- or zero-extended; 0 for stores and errors.
REQ-013 rsp_err  output  1  access was illegal (bad DMCtrl, or misaligned when trapping).

Function
REQ-014 FSM states IDLE, ACCESS, RESP; req_ready SHALL be 1 only in IDLE.
REQ-015 IDLE: req_valid=1 SHALL latch Address, DataWr, DMWr, DMCtrl and go to ACCESS; otherwise stay.
REQ-016 ACCESS: exactly one array read or one byte-enabled write SHALL occur, then go to RESP.
REQ-017 RESP: rsp_valid=1 with DataRd/rsp_err stable; rsp_ready=1 SHALL go to IDLE, else hold.
REQ-018 Latency: rsp_valid SHALL rise exactly 2 cycles after the accepting edge; min 3 cycles per transaction.
REQ-019 Word index = Address[log2(DEPTH_WORDS)+1:2]; upper address bits SHALL be ignored (wrap-around).
REQ-020 Loads: byte lane Address[1:0], half lane Address[1]; B/H sign-extend, BU/HU zero-extend, W unchanged.
REQ-021 Stores: SB writes lane Address[1:0] only, SH writes 2 lanes at Address[1], SW all 4; unwritten bytes SHALL keep prior value.
REQ-022 DMCtrl 011/110/111, or store with DMCtrl 100/101: rsp_err=1, no write, DataRd=0.
REQ-023 Store followed immediately by load of same word SHALL return the newly written data.
REQ-024 Input changes while not in IDLE SHALL have no effect.

Reset
REQ-025 rst=1 SHALL immediately force IDLE, req_ready=1, rsp_valid=0, rsp_err=0, DataRd=0.
REQ-026 Reset during ACCESS before the clock edge SHALL suppress that write; array contents are not cleared by reset.

Configuration
REQ-027 Macro DMEM_MISALIGN_TRAP_EN defined: H/HU with Address[0]=1, or W with Address[1:0]!=0, SHALL give rsp_err=1, no write, DataRd=0.
REQ-028 Macro DMEM_MISALIGN_TRAP_EN undefined: misaligned low address bits SHALL be forced to zero (H: bit0, W: bits1:0) and the access completes with rsp_err=0.

Structure
REQ-029 Shared package dm_pkg SHALL hold the DMCtrl encoding constants and the FSM state typedef.
REQ-030 Combinational sub-module dmem_lane_fmt SHALL produce store byte-enables/shifted data and load extraction/extension.

Verification
REQ-031 SW 0x12345678 @0x100, then LW @0x100 -> DataRd=0x12345678, rsp_err=0, rsp_valid 2 cycles after accept.
REQ-032 After REQ-031, SB 0xAB @0x101, LB @0x101 -> 0xFFFFFFAB; LBU @0x101 -> 0x000000AB; LW @0x100 -> 0x1234AB78.
REQ-033 After REQ-032, LH @0x102 -> 0x00001234; SH 0x8001 @0x102, LH @0x102 -> 0xFFFF8001.
REQ-034 LW @0x103: with macro -> rsp_err=1, DataRd=0; without -> DataRd = word @0x100, rsp_err=0.
REQ-035 rsp_ready held 0 for 5 cycles in RESP -> rsp_valid/DataRd stable, req_ready=0 throughout; DMCtrl=111 load -> rsp_err=1.
REQ-036 SW 0xDEADBEEF @0x200, rst pulsed during ACCESS -> outputs reset at once; LW @0x200 returns the prior value.
